// File: rtl/acc_reg_stack.sv
// Accumulator register with priority command decode, carry flag and an
// optional save/restore stack (built only when ACC_STACK_EN is defined).
// Ports: clk, rst_n (sync, active-low); commands writealu, writebus, read,
//   rstac, incac, decac, push, pop; data_inalu/data_inbus load sources;
//   data_out registered read-out; data_store live acc; zflag, nflag, cflag;
//   stk_full, stk_empty, stk_err stack status.
module acc_reg_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             writealu,
   input  logic             writebus,
   input  logic             read,
   input  logic             rstac,
   input  logic             incac,
   input  logic             decac,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_inalu,
   input  logic [WIDTH-1:0] data_inbus,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] data_store,
   output logic             zflag,
   output logic             nflag,
   output logic             cflag,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   logic [WIDTH-1:0] acc;
   logic             higher;

   // Any command that outranks pop/push this cycle.
   assign higher     = rstac | writealu | writebus | incac | decac;
   assign data_store = acc;
   assign zflag      = (acc == '0);
   assign nflag      = acc[WIDTH-1];

`ifdef ACC_STACK_EN
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] stack [DEPTH];
   logic [SPW-1:0]   sp;
   logic [SPW-1:0]   sp_dec;
   logic             err;
   logic             do_pop;
   logic             do_push;

   assign sp_dec    = sp - SPW'(1);
   assign stk_full  = (sp == SPW'(DEPTH));
   assign stk_empty = (sp == '0);
   assign stk_err   = err;
   assign do_pop    = ~higher & pop;
   assign do_push   = ~higher & ~pop & push;

   // Storage is never cleared; reset only rewinds sp.
   always_ff @(posedge clk) begin
      if (rst_n && do_push && !stk_full)
         stack[sp[IW-1:0]] <= acc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp  <= '0;
         err <= 1'b0;
      end else if (rstac) begin
         err <= 1'b0;
      end else if (do_pop) begin
         if (stk_empty) err <= 1'b1;
         else           sp  <= sp_dec;
      end else if (do_push) begin
         if (stk_full) err <= 1'b1;
         else          sp  <= sp + SPW'(1);
      end
   end
`else
   logic unused_stack;

   assign unused_stack = push | pop;
   assign stk_full     = 1'b0;
   assign stk_empty    = 1'b1;
   assign stk_err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= '0;
         data_out <= '0;
         cflag    <= 1'b0;
      end else begin
         // Read captures the pre-update value regardless of the command.
         if (read) data_out <= acc;
         if (rstac) begin
            acc   <= '0;
            cflag <= 1'b0;
         end else if (writealu) begin
            acc   <= data_inalu;
            cflag <= 1'b0;
         end else if (writebus) begin
            acc   <= data_inbus;
            cflag <= 1'b0;
         end else if (incac) begin
            acc   <= acc + WIDTH'(1);
            cflag <= &acc;
         end else if (decac) begin
            acc   <= acc - WIDTH'(1);
            cflag <= ~|acc;
`ifdef ACC_STACK_EN
         end else if (do_pop && !stk_empty) begin
            acc   <= stack[sp_dec[IW-1:0]];
            cflag <= 1'b0;
`endif
         end
      end
   end

endmodule
